// File: rtl/cpu_mc.sv
// Multi-cycle 8-register CPU: req/ack instruction fetch, DATA_W datapath, C/Z flags, HALT, single-step.
// Also scans the 8x8 LED matrix from a free-running counter and shows r6[3:0] on the status LEDs.
module cpu_mc #(
  parameter int DATA_W = 8,
  parameter int ADR_W  = 11,
  parameter int SCAN_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        btn,
  input  logic              step_mode,
  input  logic              step,
  output logic [ADR_W-1:0]  adr,
  output logic              mem_req,
  input  logic              mem_ack,
  input  logic [15:0]       dout,
  output logic [3:0]        led,
  output logic [7:0]        row,
  output logic [7:0]        col,
  output logic              halted
);

  typedef enum logic [2:0] {IDLE, FETCH, EXEC, STEPW, HALT} state_t;

  localparam logic [4:0] OP_ADD = 5'b01000, OP_OR  = 5'b01001, OP_AND = 5'b01010,
                         OP_XOR = 5'b01011, OP_INC = 5'b01100, OP_NOT = 5'b01101,
                         OP_ROR = 5'b01110, OP_ROL = 5'b01111, OP_JNC = 5'b10000,
                         OP_JMP = 5'b10010, OP_MVI = 5'b10100, OP_JZ  = 5'b10110,
                         OP_HLT = 5'b11111;

  state_t              state, state_nxt;
  logic [15:0]         ir;
  logic [ADR_W-1:0]    pc, pc_nxt, imm_adr;
  logic [DATA_W-1:0]   regs [8];
  logic [DATA_W-1:0]   rview [8];
  logic [DATA_W-1:0]   src, res;
  logic [DATA_W:0]     sum;
  logic [4:0]          op;
  logic [2:0]          sss, wdst, row_idx;
  logic [7:0]          imm, disp;
  logic                wen, c_flag, z_flag, c_nxt, z_nxt;
  logic [SCAN_W-1:0]   scan;

  assign op      = ir[7:3];
  assign sss     = ir[2:0];
  assign imm     = ir[15:8];
  assign imm_adr = ADR_W'(imm);

  // r5 and r7 are not storage: they alias the buttons and the program counter
  always_comb begin
    for (int k = 0; k < 8; k++) rview[k] = regs[k];
    rview[5] = DATA_W'(btn);
    rview[7] = DATA_W'(pc);
  end

  assign src = rview[sss];

  always_comb begin
    wen    = 1'b0;
    wdst   = sss;
    res    = src;
    sum    = '0;
    c_nxt  = c_flag;
    z_nxt  = z_flag;
    pc_nxt = pc + 1'b1;
    casez (op)
      5'b00???: begin wen = 1'b1; wdst = op[2:0]; res = src; end
      OP_ADD: begin
        sum = {1'b0, rview[0]} + {1'b0, src};
        wen = 1'b1; wdst = 3'd0; res = sum[DATA_W-1:0];
        c_nxt = sum[DATA_W]; z_nxt = (res == '0);
      end
      OP_OR:  begin wen = 1'b1; wdst = 3'd0; res = rview[0] | src; z_nxt = (res == '0); end
      OP_AND: begin wen = 1'b1; wdst = 3'd0; res = rview[0] & src; z_nxt = (res == '0); end
      OP_XOR: begin wen = 1'b1; wdst = 3'd0; res = rview[0] ^ src; z_nxt = (res == '0); end
      OP_INC: begin
        sum = {1'b0, src} + 1'b1;
        wen = 1'b1; res = sum[DATA_W-1:0];
        c_nxt = sum[DATA_W]; z_nxt = (res == '0);
      end
      OP_NOT: begin wen = 1'b1; res = ~src; end
      OP_ROR: begin wen = 1'b1; res = {src[0], src[DATA_W-1:1]}; end
      OP_ROL: begin wen = 1'b1; res = {src[DATA_W-2:0], src[DATA_W-1]}; end
      OP_JNC: begin pc_nxt = c_flag ? pc + 1'b1 : imm_adr; c_nxt = 1'b0; end
      OP_JMP: pc_nxt = imm_adr;
      OP_MVI: begin wen = 1'b1; res = DATA_W'(imm); end
      OP_JZ:  pc_nxt = z_flag ? imm_adr : pc + 1'b1;
      OP_HLT: pc_nxt = pc;
      default: ;
    endcase
    if (wen && wdst == 3'd7) pc_nxt = ADR_W'(res);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  state_nxt = FETCH;
      FETCH: if (mem_ack) state_nxt = EXEC;
      EXEC:  begin
        if (op == OP_HLT)  state_nxt = HALT;
        else if (step_mode) state_nxt = STEPW;
        else               state_nxt = FETCH;
      end
      STEPW: if (step) state_nxt = FETCH;
      HALT:  state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      mem_req <= 1'b0;
      halted  <= 1'b0;
    end else begin
      state   <= state_nxt;
      mem_req <= (state_nxt == FETCH);
      halted  <= (state_nxt == HALT);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < 8; k++) regs[k] <= '0;
      ir     <= '0;
      pc     <= '0;
      c_flag <= 1'b0;
      z_flag <= 1'b0;
      scan   <= '0;
    end else begin
      scan <= scan + 1'b1;
      if (state == FETCH && mem_ack) ir <= dout;
      if (state == EXEC) begin
        pc     <= pc_nxt;
        c_flag <= c_nxt;
        z_flag <= z_nxt;
        if (wen && wdst != 3'd5 && wdst != 3'd7) regs[wdst] <= res;
      end
    end
  end

  assign adr     = pc;
  assign led     = rview[6][3:0];
  assign row_idx = scan[SCAN_W-1 -: 3];
  assign disp    = rview[row_idx][7:0];
  assign col     = ~(8'h80 >> row_idx);

  always_comb begin
    for (int k = 0; k < 8; k++) row[k] = disp[7-k];
  end

endmodule

// File: tb/tb_cpu_mc.sv
// Directed bench for cpu_mc: fetch-address scoreboard, register contents observed through the LED scan.
module tb_cpu_mc;
  localparam int DW = 8, AW = 11, SW = 3;

  localparam logic [4:0] MOV0 = 5'b00000, ADD = 5'b01000, XOR_ = 5'b01011, INC = 5'b01100,
                         NOT_ = 5'b01101, ROL = 5'b01111, JNC = 5'b10000, MVI = 5'b10100,
                         JZ = 5'b10110, HLT = 5'b11111;

  logic          clk = 1'b0;
  logic          reset, step_mode, step, mem_req, mem_ack, halted;
  logic [3:0]    btn, led;
  logic [AW-1:0] adr;
  logic [15:0]   dout;
  logic [7:0]    row, col;

  logic [15:0]   imem [2048];
  logic [AW-1:0] exp_adr [$];
  logic [AW-1:0] held_adr;
  int            checks = 0, failures = 0;
  int            ws = 0, wcnt = 0, cyc = 0, n;
  bit            tie_ack = 1'b0;

  always #5 clk = ~clk;

  cpu_mc #(.DATA_W(DW), .ADR_W(AW), .SCAN_W(SW)) dut (
    .clk(clk), .reset(reset), .btn(btn), .step_mode(step_mode), .step(step),
    .adr(adr), .mem_req(mem_req), .mem_ack(mem_ack), .dout(dout),
    .led(led), .row(row), .col(col), .halted(halted)
  );

  function automatic logic [15:0] enc(input logic [4:0] op, input logic [2:0] s, input logic [7:0] imm);
    return {imm, op, s};
  endfunction

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int k = 0; k < 8; k++) r[k] = v[7-k];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle; also plays instruction memory and pops the fetch scoreboard.
  task automatic tick();
    @(negedge clk);
    cyc++;
    dout = imem[adr];
    if (tie_ack) mem_ack = 1'b1;
    else if (mem_req) begin
      mem_ack = (wcnt >= ws);
      if (wcnt > 0) chk("adr_hold", adr, held_adr);
      held_adr = adr;
      wcnt++;
    end else begin
      mem_ack = 1'b0;
      wcnt = 0;
    end
    if (mem_req && mem_ack) begin
      checks++;
      assert (exp_adr.size() != 0) else begin
        failures++;
        $error("FAIL fetch_unexpected: observed adr %0h expected no fetch", adr);
      end
      if (exp_adr.size() != 0) chk("fetch_adr", adr, exp_adr.pop_front());
    end
  endtask

  task automatic clear_mem();
    for (int k = 0; k < 2048; k++) imem[k] = enc(HLT, 3'd0, 8'h00);
    exp_adr.delete();
  endtask

  task automatic do_reset();
    reset = 1'b0; step = 1'b0; mem_ack = 1'b0; wcnt = 0;
    #1;
    chk("rst_adr", adr, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_halted", halted, 0);
    chk("rst_led", led, 0);
    chk("rst_col", col, 8'h7F);
    chk("rst_row", row, 8'h00);
    tick(); tick();
    reset = 1'b1;
    cyc = 0;
  endtask

  task automatic run_until_halt(input int max, output int cnt);
    cnt = 0;
    while (!halted && cnt < max) begin tick(); cnt++; end
    chk("halt_reached", halted, 1);
  endtask

  task automatic check_reg(input int idx, input logic [7:0] val, input string tag);
    logic [7:0] want_col;
    int k;
    want_col = ~(8'h80 >> idx);
    k = 0;
    while (col !== want_col && k < 20) begin tick(); k++; end
    chk({tag, "_col"}, col, want_col);
    chk(tag, row, rev8(val));
  endtask

  task automatic pulse_step();
    step = 1'b1; tick(); step = 1'b0;
  endtask

  initial begin
    int exp_req [8]  = '{1, 0, 1, 0, 1, 0, 0, 0};
    int exp_a [8]    = '{0, 0, 1, 1, 2, 2, 2, 2};
    int exp_h [8]    = '{0, 0, 0, 0, 0, 0, 1, 1};
    int exp_led [8]  = '{0, 0, 0, 0, 5, 5, 5, 5};
    logic [7:0] ecol;
    reset = 1'b0; btn = 4'h0; step_mode = 1'b0; step = 1'b0; mem_ack = 1'b0; dout = '0;

    // Load and fetch timing with ack tied high; HLT freezes the PC.
    clear_mem();
    imem[0] = enc(MVI, 3'd0, 8'h05);
    imem[1] = enc(MOV0 | 5'd6, 3'd0, 8'h00);
    exp_adr.push_back(0); exp_adr.push_back(1); exp_adr.push_back(2);
    tie_ack = 1'b1;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      tick();
      ecol = ~(8'h80 >> (cyc % 8));
      chk("t1_req", mem_req, exp_req[k]);
      chk("t1_adr", adr, exp_a[k]);
      chk("t1_halted", halted, exp_h[k]);
      chk("t1_led", led, exp_led[k]);
      chk("t1_col", col, ecol);
    end
    repeat (20) tick();
    chk("hlt_adr", adr, 2);
    chk("hlt_req", mem_req, 0);
    chk("hlt_halted", halted, 1);
    chk("t1_sb", exp_adr.size(), 0);

    // Carry, JNC (not taken then taken), JZ not taken, r5 write discarded, write to r7.
    clear_mem();
    imem[0]  = enc(MVI, 3'd0, 8'hF0);
    imem[1]  = enc(MVI, 3'd1, 8'h20);
    imem[2]  = enc(ADD, 3'd1, 8'h00);
    imem[3]  = enc(JNC, 3'd0, 8'h00);
    imem[4]  = enc(JZ,  3'd0, 8'h0A);
    imem[5]  = enc(JNC, 3'd0, 8'h08);
    imem[8]  = enc(MOV0 | 5'd6, 3'd0, 8'h00);
    imem[9]  = enc(MVI, 3'd5, 8'h33);
    imem[10] = enc(MVI, 3'd4, 8'h0C);
    imem[11] = enc(MOV0 | 5'd7, 3'd4, 8'h00);
    foreach (exp_a[k]) ;
    for (int a = 0; a <= 5; a++) exp_adr.push_back(AW'(a));
    for (int a = 8; a <= 12; a++) exp_adr.push_back(AW'(a));
    do_reset();
    run_until_halt(200, n);
    chk("t2_cycles", n, 23);
    chk("t2_sb", exp_adr.size(), 0);
    check_reg(0, 8'h10, "t2_r0");
    check_reg(1, 8'h20, "t2_r1");
    check_reg(4, 8'h0C, "t2_r4");
    check_reg(5, 8'h00, "t2_r5");
    check_reg(6, 8'h10, "t2_r6");
    check_reg(7, 8'h0C, "t2_r7");

    // Three wait states per fetch, ROL wrap, XOR to zero sets Z, JZ taken, NOT.
    clear_mem();
    imem[0]     = enc(MVI,  3'd2, 8'h81);
    imem[1]     = enc(ROL,  3'd2, 8'h00);
    imem[2]     = enc(MVI,  3'd0, 8'h5A);
    imem[3]     = enc(XOR_, 3'd0, 8'h00);
    imem[4]     = enc(JZ,   3'd0, 8'h10);
    imem[16]    = enc(NOT_, 3'd1, 8'h00);
    imem[17]    = enc(MOV0 | 5'd6, 3'd2, 8'h00);
    for (int a = 0; a <= 4; a++) exp_adr.push_back(AW'(a));
    for (int a = 16; a <= 18; a++) exp_adr.push_back(AW'(a));
    tie_ack = 1'b0; ws = 3;
    do_reset();
    run_until_halt(400, n);
    chk("t3_cycles", n, 41);
    chk("t3_led", led, 4'h3);
    chk("t3_sb", exp_adr.size(), 0);
    check_reg(2, 8'h03, "t3_rol");
    check_reg(0, 8'h00, "t3_xor");
    check_reg(1, 8'hFF, "t3_not");

    // Single-step: park in STEPW, one instruction per pulse, a pulse during FETCH is ignored.
    clear_mem();
    imem[0] = enc(MVI, 3'd6, 8'h01);
    imem[1] = enc(INC, 3'd6, 8'h00);
    imem[2] = enc(INC, 3'd6, 8'h00);
    exp_adr.push_back(0); exp_adr.push_back(1); exp_adr.push_back(2);
    ws = 0; step_mode = 1'b1;
    do_reset();
    repeat (10) tick();
    chk("st_park_req", mem_req, 0);
    chk("st_park_adr", adr, 1);
    chk("st_park_led", led, 1);
    ws = 3;
    pulse_step();
    chk("st_fetch_req", mem_req, 1);
    pulse_step();
    repeat (15) tick();
    chk("st_one_adr", adr, 2);
    chk("st_one_led", led, 2);
    chk("st_one_req", mem_req, 0);
    pulse_step();
    repeat (15) tick();
    chk("st_two_adr", adr, 3);
    chk("st_two_led", led, 3);
    chk("st_sb", exp_adr.size(), 0);

    // Reset asserted mid-fetch with ack withheld.
    ws = 100000;
    pulse_step();
    tick(); tick();
    chk("mf_req", mem_req, 1);
    chk("mf_adr", adr, 3);
    #2 reset = 1'b0;
    #1;
    chk("mf_rst_req", mem_req, 0);
    chk("mf_rst_adr", adr, 0);
    chk("mf_rst_led", led, 0);
    chk("mf_rst_halted", halted, 0);
    chk("mf_rst_col", col, 8'h7F);
    chk("mf_rst_row", row, 8'h00);

    // Display scan with a 3-bit counter, including the button alias r5.
    clear_mem();
    imem[0] = enc(MVI, 3'd3, 8'h01);
    exp_adr.push_back(0); exp_adr.push_back(1);
    step_mode = 1'b0; ws = 0; tie_ack = 1'b1;
    do_reset();
    run_until_halt(50, n);
    check_reg(3, 8'h01, "disp_r3");
    btn = 4'hA;
    check_reg(5, 8'h0A, "disp_btn");
    chk("disp_sb", exp_adr.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_mc.md
# cpu_mc

Parametrised multi-cycle successor to the 8-register LED-matrix CPU. It fetches 16-bit instructions over a req/ack handshake, so instruction memory may insert wait states. It adds a DATA_W-wide datapath, a zero flag, immediate-operand jumps and loads, HALT, and single-step mode. It drives the board's 8×8 LED matrix from an internal scan counter and drives 4 status LEDs from r6.

## Interface
- DATA_W, 8: register width; legal range 8..16.
- ADR_W, 11: program-counter / instruction-address width.
- SCAN_W, 16: scan-counter width; the row index is scan[SCAN_W-1 -: 3]. Minimum 3.
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- btn  input  4  buttons, read as r5.
- step_mode  input  1  1 = single-step execution.
- step  input  1  one-cycle pulse that releases one instruction in step mode.
- adr  output  ADR_W  instruction address; always equals PC.
- mem_req  output  1  fetch request.
- mem_ack  input  1  dout is valid this cycle.
- dout  input  16  instruction word: op=dout[7:3], sss=dout[2:0], imm=dout[15:8].
- led  output  4  r6[3:0].
- row  output  8  anode drive, bit-reversed r[i][7:0].
- col  output  8  cathode drive, active-low one-hot: col[7-i]=0.
- halted  output  1  CPU is in the HALT state.

## Operation
- Register file: r0..r7, each DATA_W bits.
  - r5 reads as btn zero-extended, re-sampled every cycle. Writes to r5 are discarded.
  - r7 reads as PC, zero-extended or truncated to DATA_W.
  - A write to r7 from any non-jump instruction sets PC to that value (truncated to ADR_W); PC is not incremented.
- Flags C and Z.
  - ADD and INC set C to the carry out of bit DATA_W-1.
  - ADD, OR, AND, XOR and INC set Z to (result == 0).
  - All other instructions leave C and Z unchanged, except JNC, which clears C.
- FSM states: IDLE, FETCH, EXEC, STEPW, HALT.
  - IDLE → FETCH on the first clock edge after reset.
  - FETCH: mem_req=1. On mem_ack=1, latch dout into IR and go to EXEC. Otherwise stay in FETCH.
  - EXEC: execute IR in one cycle. Then go to HALT if the opcode is HLT, else to STEPW if step_mode=1, else to FETCH.
  - STEPW: go to FETCH on step=1.
  - HALT: exited only by reset.
- Opcodes (op):
  - 00ddd MOV: rd ← rs.
  - 01000 ADD: r0 ← r0+rs.
  - 01001 OR, 01010 AND, 01011 XOR: r0 ← r0 op rs.
  - 01100 INC: rs ← rs+1.
  - 01101 NOT: rs ← ~rs.
  - 01110 ROR, 01111 ROL: rotate rs by 1 within DATA_W.
  - 10000 JNC: PC ← imm if C=0, else PC+1; C←0 in both cases.
  - 10010 JMP: PC ← imm.
  - 10100 MVI: rs ← imm.
  - 10110 JZ: PC ← imm if Z=1, else PC+1.
  - 11111 HLT: PC unchanged.
  - All other opcodes are NOPs.
- Width rules:
  - imm is zero-extended to DATA_W and to ADR_W.
  - All arithmetic is modulo 2^DATA_W.
  - PC+1 wraps modulo 2^ADR_W.
- PC advance: every EXEC that is not a jump and not a write to r7 sets PC ← PC+1.
- Display: the scan counter increments every cycle, including in HALT.
  - i = scan[SCAN_W-1 -: 3].
  - row = {r[i][0], r[i][1], …, r[i][7]}.

## Timing
- Reset values:
  - All registers, C, Z and PC = 0. State = IDLE. mem_req=0, halted=0.
  - scan=0, so col=8'b0111_1111, row=0, led=0, adr=0.
- mem_req is a registered output, high exactly while in FETCH. adr is stable for the whole time mem_req is high.
- Latency with mem_ack tied to 1: 1 cycle IDLE after reset, then 2 cycles per instruction (FETCH, EXEC). Each wait state adds 1 cycle.
- Register, flag and PC updates become visible on the clock edge that ends EXEC.
- A step pulse outside STEPW is ignored. mem_ack outside FETCH is ignored.
- halted rises on the edge that leaves the EXEC of HLT.
- Reset asserted in any state, including mid-fetch, immediately forces the reset values. No partial instruction commits.

## Test plan
- Reset and load, ack tied to 1: program MVI r0,0x05; MOV r6,r0. Expect adr 0→1→2, mem_req pulses one cycle in two, led=4'h5 after cycle 5.
- Carry and JNC, DATA_W=8: MVI r0,0xF0; MVI r1,0x20; ADD r1; JNC 0x00. Expect r0=0x10, C=1, Z=0; JNC not taken (PC=4), then C=0.
- Wait states: delay mem_ack by 3 cycles. Expect mem_req held high and adr unchanged for 4 cycles; IR executes the cycle after ack. Also ROL of 0x81 → 0x03.
- Step mode: step_mode=1. Expect the CPU to park in STEPW with mem_req=0; each 1-cycle step pulse runs exactly one instruction; a step asserted during FETCH has no effect.
- HLT and reset mid-fetch: after HLT, expect halted=1, mem_req=0 and PC frozen indefinitely. Then assert reset while in FETCH with ack withheld; expect all outputs at reset values asynchronously.
- Display, SCAN_W=3: MVI r3,0x01. When scan=3, expect row=8'b1000_0000 and col=8'b1110_1111. Pressing btn=4'hA gives row=8'b0101_0000 when scan=5.
